bist_sequencer: RTL and testbench

Controller for the 6-bit CLA BIST datapath: sequences the pattern LFSRs, the SISR compactor and the CLA mode line through a fixed number of test patterns. It runs in one of two modes:
- Learn: records one golden signature per pattern into an internal signature RAM.
- Test: replays the same pattern sequence, compares each signature against the stored golden value and reports pass/fail, failure count and first failing pattern index.

It sits between the top-level BIST wrapper and the LFSR/CLA/SISR/comparator datapath. It replaces free-running enable wiring with a deterministic FSM.

---
 rtl/bist_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_bist_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_sequencer.sv
// bist_sequencer: run controller for the 6-bit CLA BIST datapath.
// Seeds the pattern LFSRs, steps them once per pattern, gates the SISR
// and either records golden signatures (learn) or checks against them (test).
// Optional build macro: BIST_TIMEOUT_EN bounds the wait for sig_valid in
// COMPRESS to SIG_TIMEOUT cycles; without it COMPRESS waits indefinitely.
// state_dbg mirrors the FSM state for debug and checker binding.
//
// Handshake: sig_valid is a single-cycle strobe with no back-pressure. It is
// honoured only while the FSM is in COMPRESS (sisr_en=1), where sig_in is
// sampled on the same edge; outside COMPRESS it is ignored.

module bist_sequencer #(
    parameter int NUM_PATTERNS = 14,
    parameter int SIG_W        = 4,
    parameter int SIG_TIMEOUT  = 15,
    localparam int IW          = $clog2(NUM_PATTERNS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          run_mode,
    input  logic          cin_cfg,
    input  logic          abort,
    input  logic [SIG_W-1:0] sig_in,
    input  logic          sig_valid,
    output logic          lfsr_clr,
    output logic          lfsr_en,
    output logic          sisr_en,
    output logic          cut_mode,
    output logic          cut_cin,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          error,
    output logic          golden_valid,
    output logic [IW:0]   fail_count,
    output logic [IW-1:0] first_fail_idx,
    output logic [2:0]    state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEED     = 3'd1,
        S_ADVANCE  = 3'd2,
        S_COMPRESS = 3'd3,
        S_CAPTURE  = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PATTERNS - 1);

    state_t           state;
    logic [IW-1:0]    idx;
    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] golden [NUM_PATTERNS];
    logic             in_run;
    logic             abort_hit;
    logic             golden_we;

`ifdef BIST_TIMEOUT_EN
    localparam int TW = $clog2(SIG_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(SIG_TIMEOUT - 1);
    logic [TW-1:0] tcnt;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (SIG_TIMEOUT > 0);
`endif

    assign state_dbg = state;
    assign in_run    = (state == S_SEED) || (state == S_ADVANCE) ||
                       (state == S_COMPRESS) || (state == S_CAPTURE);
    assign abort_hit = abort && in_run;
    assign golden_we = !rst && !abort_hit && (state == S_CAPTURE) && !cut_mode;

    // Golden signature RAM: written once per pattern during a learn run, no reset.
    always_ff @(posedge clk) begin
        if (golden_we) begin
            golden[idx] <= sig_q;
        end
    end

    // Run FSM with registered strobes and status; abort overrides everything but rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            lfsr_clr       <= 1'b0;
            lfsr_en        <= 1'b0;
            sisr_en        <= 1'b0;
            cut_mode       <= 1'b0;
            cut_cin        <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            error          <= 1'b0;
            golden_valid   <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            idx            <= '0;
            sig_q          <= '0;
`ifdef BIST_TIMEOUT_EN
            tcnt           <= '0;
`endif
        end else if (abort_hit) begin
            state    <= S_IDLE;
            lfsr_clr <= 1'b0;
            lfsr_en  <= 1'b0;
            sisr_en  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            // A partially written golden set is unusable.
            if (!cut_mode) golden_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cut_mode       <= run_mode;
                        cut_cin        <= cin_cfg;
                        idx            <= '0;
                        fail_count     <= '0;
                        first_fail_idx <= '0;
                        if (run_mode && !golden_valid) begin
                            // Nothing to compare against: finish immediately.
                            state <= S_DONE;
                            done  <= 1'b1;
                            error <= 1'b1;
                            pass  <= 1'b0;
                        end else begin
                            state    <= S_SEED;
                            busy     <= 1'b1;
                            lfsr_clr <= 1'b1;
                            done     <= 1'b0;
                            error    <= 1'b0;
                            pass     <= 1'b1;
                        end
                    end
                end
                S_SEED: begin
                    lfsr_clr <= 1'b0;
                    lfsr_en  <= 1'b1;
                    state    <= S_ADVANCE;
                    if (!cut_mode) golden_valid <= 1'b0;
                end
                S_ADVANCE: begin
                    lfsr_en <= 1'b0;
                    sisr_en <= 1'b1;
                    state   <= S_COMPRESS;
`ifdef BIST_TIMEOUT_EN
                    tcnt    <= '0;
`endif
                end
                S_COMPRESS: begin
                    if (sig_valid) begin
                        sig_q   <= sig_in;
                        sisr_en <= 1'b0;
                        state   <= S_CAPTURE;
                    end
`ifdef BIST_TIMEOUT_EN
                    else if (tcnt == TMO_LAST) begin
                        sisr_en <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        error   <= 1'b1;
                        pass    <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
`endif
                end
                S_CAPTURE: begin
                    if (cut_mode && (sig_q != golden[idx])) begin
                        if (fail_count != '1) fail_count <= fail_count + 1'b1;
                        if (fail_count == '0) first_fail_idx <= idx;
                        pass <= 1'b0;
                    end
                    if (idx == LAST_IDX) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        if (!cut_mode) golden_valid <= 1'b1;
                    end else begin
                        idx     <= idx + 1'b1;
                        lfsr_en <= 1'b1;
                        state   <= S_ADVANCE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bist_sequencer.sv
// tb_bist_sequencer: directed table runs, randomized runs against a
// signature-level reference model, and hand sequences for the no-golden
// error path, abort, mid-run reset and (with BIST_TIMEOUT_EN) timeout.

module tb_bist_sequencer;

    localparam int NP         = 14;
    localparam int SW         = 4;
    localparam int IW         = $clog2(NP);
    localparam int RUN_BUDGET = 2000;
    localparam int FC_MAX     = (1 << (IW + 1)) - 1;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic rst, start, run_mode, cin_cfg, abort, sig_valid;
    logic [SW-1:0] sig_in;
    logic lfsr_clr, lfsr_en, sisr_en, cut_mode, cut_cin, busy, done, pass, error, golden_valid;
    logic [IW:0]   fail_count;
    logic [IW-1:0] first_fail_idx;
    logic [2:0]    state_dbg;

    always #5 clk = ~clk;

    bist_sequencer #(.NUM_PATTERNS(NP), .SIG_W(SW), .SIG_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .start(start), .run_mode(run_mode), .cin_cfg(cin_cfg),
        .abort(abort), .sig_in(sig_in), .sig_valid(sig_valid),
        .lfsr_clr(lfsr_clr), .lfsr_en(lfsr_en), .sisr_en(sisr_en),
        .cut_mode(cut_mode), .cut_cin(cut_cin), .busy(busy), .done(done),
        .pass(pass), .error(error), .golden_valid(golden_valid),
        .fail_count(fail_count), .first_fail_idx(first_fail_idx), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [SW-1:0] sig_v [NP];     // signature the SISR stub returns per pattern
    int            k_v   [NP];     // COMPRESS cycle on which sig_valid is raised
    logic [SW-1:0] golden_m [NP];  // model of the golden RAM
    bit            gv_m = 1'b0;    // model of golden_valid
    logic [IW-1:0] exp_q [$];      // expected mismatching pattern indices

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic predict(input bit mode, output int e_err, output int e_pass, output int e_fc,
                           output int e_ffi, output int e_gv, output int e_cycles, output int e_sisr);
        exp_q.delete();
        e_fc = 0; e_ffi = 0; e_sisr = 0; e_cycles = 0;
        if (mode && !gv_m) begin
            e_err = 1; e_pass = 0;
        end else begin
            e_err = 0;
            e_cycles = 1;
            for (int i = 0; i < NP; i++) begin
                e_cycles += k_v[i] + 2;
                e_sisr   += k_v[i];
                if (mode && (sig_v[i] !== golden_m[i])) exp_q.push_back(IW'(i));
            end
            e_fc   = (exp_q.size() > FC_MAX) ? FC_MAX : exp_q.size();
            e_ffi  = (exp_q.size() > 0) ? int'(exp_q[0]) : 0;
            e_pass = (exp_q.size() == 0);
            if (!mode) begin
                for (int i = 0; i < NP; i++) golden_m[i] = sig_v[i];
                gv_m = 1'b1;
            end
        end
        e_gv = gv_m;
    endtask

    // ---------------- driver: start a run and act as the SISR stub ----------------
    task automatic do_run(input bit mode, input bit cin, input int abort_pat, input bit noise,
                          output int cycles, output int n_clr, output int n_en, output int n_sisr,
                          output bit hold_ok, output bit finished);
        int pat;
        int ccount;
        pat = 0; ccount = 0; cycles = 0;
        n_clr = 0; n_en = 0; n_sisr = 0; hold_ok = 1'b1; finished = 1'b0;
        start = 1'b1; run_mode = mode; cin_cfg = cin;
        @(negedge clk);
        start = 1'b0;
        while (cycles < RUN_BUDGET) begin
            if (done === 1'b1) begin
                finished = 1'b1;
                break;
            end
            n_clr  += int'(lfsr_clr);
            n_en   += int'(lfsr_en);
            n_sisr += int'(sisr_en);
            if (busy !== 1'b1 || cut_mode !== mode || cut_cin !== cin || (lfsr_en && sisr_en))
                hold_ok = 1'b0;
            sig_valid = 1'b0;
            sig_in    = noise ? SW'($urandom) : '0;
            if (sisr_en === 1'b1 && pat < NP) begin
                ccount++;
                if (pat == abort_pat) begin
                    abort = 1'b1;
                    sig_valid = 1'b1;   // abort must win over a simultaneous strobe
                end else if (ccount == k_v[pat]) begin
                    sig_valid = 1'b1;
                    sig_in    = sig_v[pat];
                    pat++;
                    ccount = 0;
                end
            end else if (noise && $urandom_range(0, 3) == 0) begin
                sig_valid = 1'b1;       // stray strobe outside COMPRESS
            end
            @(negedge clk);
            cycles++;
            if (abort) begin
                abort = 1'b0;
                break;
            end
        end
        sig_valid = 1'b0;
    endtask

    task automatic exec_run(input string name, input bit mode, input bit cin, input bit noise,
                            input int e_error, input int e_pass, input int e_fc, input int e_ffi,
                            input int e_gv, input int e_cycles, input int e_clr, input int e_en,
                            input int e_sisr, input bit chk_hold);
        int cycles, n_clr, n_en, n_sisr;
        bit hold_ok, finished;
        do_run(mode, cin, -1, noise, cycles, n_clr, n_en, n_sisr, hold_ok, finished);
        chk({name, ".finished"}, finished, 1);
        chk({name, ".cycles"}, cycles, e_cycles);
        chk({name, ".done"}, done, 1);
        chk({name, ".busy"}, busy, 0);
        chk({name, ".error"}, error, e_error);
        chk({name, ".pass"}, pass, e_pass);
        chk({name, ".fail_count"}, fail_count, e_fc);
        chk({name, ".first_fail_idx"}, first_fail_idx, e_ffi);
        chk({name, ".golden_valid"}, golden_valid, e_gv);
        chk({name, ".cut_mode"}, cut_mode, mode);
        chk({name, ".cut_cin"}, cut_cin, cin);
        chk({name, ".lfsr_clr_cycles"}, n_clr, e_clr);
        chk({name, ".lfsr_en_cycles"}, n_en, e_en);
        chk({name, ".sisr_en_cycles"}, n_sisr, e_sisr);
        if (chk_hold) chk({name, ".busy_mode_held"}, hold_ok, 1);
    endtask

    task automatic check_reset(input string name);
        chk({name, ".lfsr_clr"}, lfsr_clr, 0);
        chk({name, ".lfsr_en"}, lfsr_en, 0);
        chk({name, ".sisr_en"}, sisr_en, 0);
        chk({name, ".cut_mode"}, cut_mode, 0);
        chk({name, ".cut_cin"}, cut_cin, 0);
        chk({name, ".busy"}, busy, 0);
        chk({name, ".done"}, done, 0);
        chk({name, ".pass"}, pass, 0);
        chk({name, ".error"}, error, 0);
        chk({name, ".golden_valid"}, golden_valid, 0);
        chk({name, ".fail_count"}, fail_count, 0);
        chk({name, ".first_fail_idx"}, first_fail_idx, 0);
    endtask

    // Test start with no golden data: DONE+error next cycle, no strobes at all.
    task automatic check_no_golden(input string name);
        int strobes;
        strobes = 0;
        start = 1'b1; run_mode = 1'b1; cin_cfg = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({name, ".done"}, done, 1);
        chk({name, ".error"}, error, 1);
        chk({name, ".pass"}, pass, 0);
        chk({name, ".busy"}, busy, 0);
        for (int i = 0; i < 6; i++) begin
            strobes += int'(lfsr_clr) + int'(lfsr_en) + int'(sisr_en) + int'(busy);
            @(negedge clk);
        end
        chk({name, ".no_strobes"}, strobes, 0);
        chk({name, ".done_held"}, done, 1);
    endtask

    task automatic set_sigs(input int k);
        for (int i = 0; i < NP; i++) begin
            sig_v[i] = SW'(i) ^ 4'hA;
            k_v[i]   = k;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit            mode;
        bit            cin;
        int            k;
        int            bad_a;
        logic [SW-1:0] val_a;
        int            bad_b;
        logic [SW-1:0] val_b;
        int            e_pass;
        int            e_fc;
        int            e_ffi;
        int            e_cycles;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int e_err, e_pass, e_fc, e_ffi, e_gv, e_cycles, e_sisr;
        int cycles, n_clr, n_en, n_sisr;
        bit hold_ok, finished, mode;

        tbl[0] = '{1'b0, 1'b0, 3, -1, 4'h0, -1, 4'h0, 1, 0, 0, 71};  // learn
        tbl[1] = '{1'b1, 1'b1, 3, -1, 4'h0, -1, 4'h0, 1, 0, 0, 71};  // clean test
        tbl[2] = '{1'b1, 1'b0, 3,  5, 4'h0,  9, 4'h1, 0, 2, 5, 71};  // two corrupted
        tbl[3] = '{1'b1, 1'b1, 1, -1, 4'h0, -1, 4'h0, 1, 0, 0, 43};  // fastest SISR
        tbl[4] = '{1'b1, 1'b0, 2,  0, 4'h0, 13, 4'h0, 0, 2, 0, 57};  // first and last bad
        tbl[5] = '{1'b0, 1'b1, 1, -1, 4'h0, -1, 4'h0, 1, 0, 0, 43};  // relearn
        tbl[6] = '{1'b1, 1'b0, 4, 13, 4'hF, -1, 4'h0, 0, 1, 13, 85}; // last bad only

        rst = 1'b1; start = 1'b0; run_mode = 1'b0; cin_cfg = 1'b0;
        abort = 1'b0; sig_valid = 1'b0; sig_in = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        check_no_golden("nogold_after_reset");

        for (int t = 0; t < 7; t++) begin
            set_sigs(tbl[t].k);
            if (tbl[t].bad_a >= 0) sig_v[tbl[t].bad_a] = tbl[t].val_a;
            if (tbl[t].bad_b >= 0) sig_v[tbl[t].bad_b] = tbl[t].val_b;
            predict(tbl[t].mode, e_err, e_pass, e_fc, e_ffi, e_gv, e_cycles, e_sisr);
            exec_run($sformatf("tbl%0d", t), tbl[t].mode, tbl[t].cin, 1'b0,
                     0, tbl[t].e_pass, tbl[t].e_fc, tbl[t].e_ffi, 1, tbl[t].e_cycles,
                     1, NP, NP * tbl[t].k, 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        for (int r = 0; r < 20; r++) begin
            mode = 1'($urandom_range(0, 1));
            for (int i = 0; i < NP; i++) begin
                k_v[i] = $urandom_range(1, 4);
                if (mode && $urandom_range(0, 4) != 0) sig_v[i] = golden_m[i];
                else sig_v[i] = SW'($urandom);
            end
            predict(mode, e_err, e_pass, e_fc, e_ffi, e_gv, e_cycles, e_sisr);
            exec_run($sformatf("rnd%0d", r), mode, 1'($urandom_range(0, 1)), 1'b1,
                     e_err, e_pass, e_fc, e_ffi, e_gv, e_cycles,
                     e_err ? 0 : 1, e_err ? 0 : NP, e_sisr, e_err == 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Abort in pattern 7 of a learn run, strobing sig_valid in the same cycle.
        set_sigs(3);
        do_run(1'b0, 1'b0, 7, 1'b0, cycles, n_clr, n_en, n_sisr, hold_ok, finished);
        gv_m = 1'b0;
        chk("abort.not_finished", finished, 0);
        chk("abort.cycles", cycles, 1 + 7 * 5 + 2);
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.pass", pass, 0);
        chk("abort.strobes", {lfsr_clr, lfsr_en, sisr_en}, 0);
        chk("abort.golden_valid", golden_valid, 0);
        repeat (2) @(negedge clk);
        chk("abort.stays_idle", {busy, done, lfsr_clr, lfsr_en, sisr_en}, 0);
        check_no_golden("nogold_after_abort");

        set_sigs(3);
        predict(1'b0, e_err, e_pass, e_fc, e_ffi, e_gv, e_cycles, e_sisr);
        exec_run("relearn", 1'b0, 1'b1, 1'b0, e_err, e_pass, e_fc, e_ffi, e_gv, e_cycles,
                 1, NP, e_sisr, 1'b1);

        // Reset in the middle of a run.
        set_sigs(3);
        start = 1'b1; run_mode = 1'b1; cin_cfg = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst.busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset("midrst");
        rst = 1'b0;
        gv_m = 1'b0;
        @(negedge clk);

`ifdef BIST_TIMEOUT_EN
        // SISR never completes: 15 COMPRESS cycles, then DONE with error.
        for (int i = 0; i < NP; i++) k_v[i] = 1000;
        exec_run("timeout", 1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 0, 17, 1, 1, 15, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
